// File: rtl/sram_reg_access_cached_if.sv
// Register-bus and SRAM-arbiter signal bundle for sram_reg_access_cached.
// slave: the access block; master: decoder plus arbiter side.
interface sram_reg_access_cached_if #(
  parameter int SRAM_ADDR_WIDTH = 19,
  parameter int SRAM_DATA_WIDTH = 72,
  parameter int REG_DATA_WIDTH  = 32,
  parameter int REG_ADDR_WIDTH  = 22
);
  logic                       reg_req;
  logic                       reg_rd_wr_L;
  logic [REG_ADDR_WIDTH-1:0]  reg_addr;
  logic [REG_DATA_WIDTH-1:0]  reg_wr_data;
  logic                       reg_ack;
  logic [REG_DATA_WIDTH-1:0]  reg_rd_data;
  logic                       wr_req;
  logic [SRAM_ADDR_WIDTH-1:0] wr_addr;
  logic [SRAM_DATA_WIDTH-1:0] wr_data;
  logic                       wr_ack;
  logic                       rd_req;
  logic [SRAM_ADDR_WIDTH-1:0] rd_addr;
  logic                       rd_ack;
  logic                       rd_vld;
  logic [SRAM_DATA_WIDTH-1:0] rd_data;

  modport slave (
    input  reg_req, reg_rd_wr_L, reg_addr, reg_wr_data, wr_ack, rd_ack, rd_vld, rd_data,
    output reg_ack, reg_rd_data, wr_req, wr_addr, wr_data, rd_req, rd_addr
  );
  modport master (
    output reg_req, reg_rd_wr_L, reg_addr, reg_wr_data, wr_ack, rd_ack, rd_vld, rd_data,
    input  reg_ack, reg_rd_data, wr_req, wr_addr, wr_data, rd_req, rd_addr
  );
endinterface

// File: rtl/sram_reg_access_cached.sv
// Register-bus window onto SRAM words: read-modify-write writes, one-line word buffer,
// timeout and request-drop abort. `define SRAM_REG_CACHE_EN to let the buffer serve hits.
module sram_reg_access_cached #(
  parameter int SRAM_ADDR_WIDTH = 19,
  parameter int SRAM_DATA_WIDTH = 72,
  parameter int REG_DATA_WIDTH  = 32,
  parameter int REG_ADDR_WIDTH  = 22,
  parameter int ACK_TIMEOUT     = 1023
) (
  input  logic clk,
  input  logic reset_n,
  sram_reg_access_cached_if.slave bus,
  output logic timeout
);
  localparam int DATA_WORDS = (SRAM_DATA_WIDTH + REG_DATA_WIDTH - 1) / REG_DATA_WIDTH;
  localparam int WORDS_W    = $clog2(DATA_WORDS);
  localparam int WORDS      = 1 << WORDS_W;
  localparam int FULL_W     = WORDS * REG_DATA_WIDTH;
  localparam int WI_W       = (WORDS_W > 0) ? WORDS_W : 1;
  localparam int LINE_W     = REG_ADDR_WIDTH - WORDS_W;
  localparam int CNT_W      = $clog2(ACK_TIMEOUT + 1);
  localparam logic [31:0] DW_U = DATA_WORDS;
`ifdef SRAM_REG_CACHE_EN
  localparam bit CACHE_EN = 1'b1;
`else
  localparam bit CACHE_EN = 1'b0;
`endif

  typedef enum logic [2:0] {IDLE, RD_REQ, RD_WAIT, WR_REQ, ACK, DONE} state_t;

  state_t                     state;
  logic [LINE_W-1:0]          addr_q;
  logic [WI_W-1:0]            w_q;
  logic                       rd_q;
  logic [REG_DATA_WIDTH-1:0]  wdata_q;
  logic                       aborted;
  logic [CNT_W-1:0]           cnt;
  logic                       buf_vld;
  logic [LINE_W-1:0]          buf_tag;
  logic [SRAM_DATA_WIDTH-1:0] buf_data;

  logic [LINE_W-1:0] req_line;
  logic [WI_W-1:0]   req_w;
  logic              req_pad, hit, tmo_hit, drop;

  // Word 0 is the least significant slice, addressed by the highest low-address value.
  generate
    if (WORDS_W > 0) begin : g_w
      assign req_w = WI_W'(WORDS - 1) - bus.reg_addr[WI_W-1:0];
    end else begin : g_w0
      assign req_w = '0;
    end
  endgenerate

  assign req_line = bus.reg_addr[REG_ADDR_WIDTH-1:WORDS_W];
  assign req_pad  = 32'(req_w) >= DW_U;
  assign hit      = buf_vld && (buf_tag == req_line);
  assign tmo_hit  = cnt >= CNT_W'(ACK_TIMEOUT - 1);
  assign drop     = aborted || !bus.reg_req;

  function automatic logic [REG_DATA_WIDTH-1:0] sel_word(
    input logic [SRAM_DATA_WIDTH-1:0] d, input logic [WI_W-1:0] w);
    logic [FULL_W-1:0] x;
    x = '0;
    x[SRAM_DATA_WIDTH-1:0] = d;
    return x[32'(w)*REG_DATA_WIDTH +: REG_DATA_WIDTH];
  endfunction

  // Bits of a partial top word beyond the SRAM width fall off in the truncation.
  function automatic logic [SRAM_DATA_WIDTH-1:0] merge(
    input logic [SRAM_DATA_WIDTH-1:0] d, input logic [WI_W-1:0] w,
    input logic [REG_DATA_WIDTH-1:0] v);
    logic [FULL_W-1:0] x;
    x = '0;
    x[SRAM_DATA_WIDTH-1:0] = d;
    x[32'(w)*REG_DATA_WIDTH +: REG_DATA_WIDTH] = v;
    return x[SRAM_DATA_WIDTH-1:0];
  endfunction

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state           <= IDLE;
      addr_q          <= '0;
      w_q             <= '0;
      rd_q            <= 1'b0;
      wdata_q         <= '0;
      aborted         <= 1'b0;
      cnt             <= '0;
      buf_vld         <= 1'b0;
      buf_tag         <= '0;
      buf_data        <= '0;
      timeout         <= 1'b0;
      bus.reg_ack     <= 1'b0;
      bus.reg_rd_data <= '0;
      bus.wr_req      <= 1'b0;
      bus.wr_addr     <= '0;
      bus.wr_data     <= '0;
      bus.rd_req      <= 1'b0;
      bus.rd_addr     <= '0;
    end else begin
      timeout <= 1'b0;
      if (state == RD_REQ || state == RD_WAIT || state == WR_REQ) cnt <= cnt + 1'b1;
      case (state)
        IDLE: begin
          cnt     <= '0;
          aborted <= 1'b0;
          if (bus.reg_req) begin
            addr_q  <= req_line;
            w_q     <= req_w;
            rd_q    <= bus.reg_rd_wr_L;
            wdata_q <= bus.reg_wr_data;
            if (req_pad || (bus.reg_rd_wr_L && hit)) begin
              state           <= ACK;
              bus.reg_ack     <= 1'b1;
              bus.reg_rd_data <= (bus.reg_rd_wr_L && !req_pad) ? sel_word(buf_data, req_w) : '0;
            end else if (hit) begin
              state       <= WR_REQ;
              bus.wr_req  <= 1'b1;
              bus.wr_addr <= req_line[SRAM_ADDR_WIDTH-1:0];
              bus.wr_data <= merge(buf_data, req_w, bus.reg_wr_data);
            end else begin
              state       <= RD_REQ;
              bus.rd_req  <= 1'b1;
              bus.rd_addr <= req_line[SRAM_ADDR_WIDTH-1:0];
            end
          end
        end
        RD_REQ, RD_WAIT: begin
          if (state == RD_REQ && !bus.rd_ack) begin
            if (!bus.reg_req) begin
              bus.rd_req <= 1'b0;
              state      <= IDLE;
            end else if (tmo_hit) begin
              bus.rd_req      <= 1'b0;
              buf_vld         <= 1'b0;
              timeout         <= 1'b1;
              state           <= ACK;
              bus.reg_ack     <= 1'b1;
              bus.reg_rd_data <= '1;
            end
          end else begin
            // Read accepted: the returning data is always captured, even after a drop.
            bus.rd_req <= 1'b0;
            if (!bus.reg_req) aborted <= 1'b1;
            if (bus.rd_vld) begin
              buf_vld  <= CACHE_EN;
              buf_tag  <= addr_q;
              buf_data <= bus.rd_data;
              if (drop) begin
                state <= IDLE;
              end else if (rd_q) begin
                state           <= ACK;
                bus.reg_ack     <= 1'b1;
                bus.reg_rd_data <= sel_word(bus.rd_data, w_q);
              end else begin
                state       <= WR_REQ;
                bus.wr_req  <= 1'b1;
                bus.wr_addr <= addr_q[SRAM_ADDR_WIDTH-1:0];
                bus.wr_data <= merge(bus.rd_data, w_q, wdata_q);
              end
            end else if (tmo_hit) begin
              buf_vld <= 1'b0;
              timeout <= 1'b1;
              if (drop) begin
                state <= IDLE;
              end else begin
                state           <= ACK;
                bus.reg_ack     <= 1'b1;
                bus.reg_rd_data <= '1;
              end
            end else begin
              state <= RD_WAIT;
            end
          end
        end
        WR_REQ: begin
          if (bus.wr_ack) begin
            bus.wr_req <= 1'b0;
            buf_vld    <= CACHE_EN;
            buf_tag    <= addr_q;
            buf_data   <= bus.wr_data;
            if (!bus.reg_req) begin
              state <= IDLE;
            end else begin
              state           <= ACK;
              bus.reg_ack     <= 1'b1;
              bus.reg_rd_data <= '0;
            end
          end else if (!bus.reg_req) begin
            bus.wr_req <= 1'b0;
            state      <= IDLE;
          end else if (tmo_hit) begin
            bus.wr_req      <= 1'b0;
            buf_vld         <= 1'b0;
            timeout         <= 1'b1;
            state           <= ACK;
            bus.reg_ack     <= 1'b1;
            bus.reg_rd_data <= '1;
          end
        end
        ACK: begin
          bus.reg_ack     <= 1'b0;
          bus.reg_rd_data <= '0;
          state           <= DONE;
        end
        DONE: if (!bus.reg_req) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sram_reg_access_cached.sv
// Bench for sram_reg_access_cached: SRAM responder, directed steps and a random
// sweep checked against a word-level register view of SRAM.
module tb_sram_reg_access_cached;
  localparam int AT = 15;
`ifdef SRAM_REG_CACHE_EN
  localparam bit CACHE = 1'b1;
`else
  localparam bit CACHE = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic timeout;
  always #5 clk = ~clk;

  sram_reg_access_cached_if #(.SRAM_ADDR_WIDTH(19), .SRAM_DATA_WIDTH(72),
    .REG_DATA_WIDTH(32), .REG_ADDR_WIDTH(22)) b ();

  sram_reg_access_cached #(.SRAM_ADDR_WIDTH(19), .SRAM_DATA_WIDTH(72),
    .REG_DATA_WIDTH(32), .REG_ADDR_WIDTH(22), .ACK_TIMEOUT(AT))
    dut (.clk(clk), .reset_n(reset_n), .bus(b), .timeout(timeout));

  int total = 0, bad = 0, cyc = 0;
  int n_rd = 0, n_wr = 0, last_evt_cyc = 0;
  bit stall = 1'b0;
  logic [71:0] sram [8];
  logic [71:0] ref_mem [8];
  logic [18:0] last_wr_addr;
  logic [71:0] last_wr_data;
  bit cvalid = 1'b0;
  int ctag = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [71:0] got, input logic [71:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // SRAM arbiter: random accept delay, read data a few cycles later.
  initial begin
    logic [2:0] ra;
    b.rd_ack = 1'b0; b.rd_vld = 1'b0; b.wr_ack = 1'b0; b.rd_data = '0;
    forever begin
      @(negedge clk);
      if (!stall && reset_n && b.rd_req) begin
        ra = b.rd_addr[2:0];
        n_rd++;
        repeat ($urandom_range(0, 2)) @(negedge clk);
        b.rd_ack = 1'b1;
        @(negedge clk);
        b.rd_ack = 1'b0;
        repeat ($urandom_range(0, 2)) @(negedge clk);
        b.rd_data = sram[ra];
        b.rd_vld = 1'b1;
        last_evt_cyc = cyc;
        @(negedge clk);
        b.rd_vld = 1'b0;
        b.rd_data = '0;
      end else if (!stall && reset_n && b.wr_req) begin
        n_wr++;
        last_wr_addr = b.wr_addr;
        last_wr_data = b.wr_data;
        repeat ($urandom_range(0, 2)) @(negedge clk);
        b.wr_ack = 1'b1;
        sram[b.wr_addr[2:0]] = b.wr_data;
        last_evt_cyc = cyc;
        @(negedge clk);
        b.wr_ack = 1'b0;
      end
    end
  end

  // One complete register transaction checked against the word-level model.
  task automatic xact(input bit rd, input logic [21:0] addr, input logic [31:0] wd);
    int sa, w, lat, r0, w0, ack_c;
    bit pad, hit;
    logic [31:0] got, exp;
    logic [127:0] x, m;
    sa  = int'(addr >> 2);
    w   = 3 - int'(addr & 22'd3);
    pad = (w >= 3);
    hit = CACHE && cvalid && (ctag == sa);
    r0 = n_rd; w0 = n_wr;
    @(negedge clk);
    b.reg_req = 1'b1; b.reg_rd_wr_L = rd; b.reg_addr = addr; b.reg_wr_data = wd;
    lat = 0;
    do begin @(negedge clk); lat++; end while (!b.reg_ack && lat < 100);
    chk("ack_seen", 72'(b.reg_ack), 72'd1);
    got = b.reg_rd_data;
    ack_c = cyc;
    b.reg_req = 1'b0;
    x = {56'b0, ref_mem[sa]} >> (32 * w);
    exp = (rd && !pad) ? x[31:0] : 32'd0;
    chk("rd_data", 72'(got), 72'(exp));
    if (pad || (rd && hit)) chk("lat_hit", 72'(lat), 72'd1);
    else chk("lat_miss", 72'(ack_c), 72'(last_evt_cyc + 1));
    @(negedge clk);
    chk("ack_pulse", 72'(b.reg_ack), 72'd0);
    chk("rd_data_clr", 72'(b.reg_rd_data), 72'd0);
    chk("n_rd", 72'(n_rd - r0), (pad || hit) ? 72'd0 : 72'd1);
    chk("n_wr", 72'(n_wr - w0), (!rd && !pad) ? 72'd1 : 72'd0);
    if (!rd && !pad) begin
      m = 128'hFFFF_FFFF << (32 * w);
      x = ({56'b0, ref_mem[sa]} & ~m) | ({96'b0, wd} << (32 * w));
      ref_mem[sa] = x[71:0];
    end
    if (!pad && CACHE) begin cvalid = 1'b1; ctag = sa; end
  endtask

  initial begin
    int lat;
    bit seen;
    for (int i = 0; i < 8; i++) begin
      sram[i] = {$urandom, $urandom, $urandom};
      ref_mem[i] = sram[i];
    end
    sram[1] = 72'hAB_12345678_9ABCDEF0;
    ref_mem[1] = sram[1];
    b.reg_req = 1'b0; b.reg_rd_wr_L = 1'b1; b.reg_addr = '0; b.reg_wr_data = '0;

    repeat (2) @(negedge clk);
    chk("rst_reg_ack", 72'(b.reg_ack), 72'd0);
    chk("rst_rd_req", 72'(b.rd_req), 72'd0);
    chk("rst_wr_req", 72'(b.wr_req), 72'd0);
    chk("rst_timeout", 72'(timeout), 72'd0);
    chk("rst_rd_data", 72'(b.reg_rd_data), 72'd0);
    reset_n = 1'b1;

    // Reads of one SRAM word, then write to its middle and partial top word.
    xact(1'b1, 22'h7, 32'h0);
    xact(1'b1, 22'h6, 32'h0);
    xact(1'b0, 22'h6, 32'hCAFEF00D);
    chk("t2_wr_addr", 72'(last_wr_addr), 72'd1);
    chk("t2_wr_data", last_wr_data, 72'hAB_CAFEF00D_9ABCDEF0);
    xact(1'b0, 22'h5, 32'h123456FF);
    chk("t3_top_byte", 72'(last_wr_data[71:64]), 72'hFF);
    xact(1'b1, 22'h5, 32'h0);
    xact(1'b1, 22'h4, 32'h0);
    xact(1'b0, 22'h4, 32'hDEADBEEF);

    // Arbiter never accepts: request must time out.
    stall = 1'b1;
    @(negedge clk);
    b.reg_req = 1'b1; b.reg_rd_wr_L = 1'b1; b.reg_addr = 22'h3;
    lat = 0;
    do begin @(negedge clk); lat++; end while (!b.reg_ack && lat < 40);
    chk("t5_lat", 72'(lat), 72'd16);
    chk("t5_timeout", 72'(timeout), 72'd1);
    chk("t5_rd_data", 72'(b.reg_rd_data), 72'hFFFF_FFFF);
    chk("t5_rd_req", 72'(b.rd_req), 72'd0);
    b.reg_req = 1'b0;
    @(negedge clk);
    chk("t5_tmo_pulse", 72'(timeout), 72'd0);
    cvalid = 1'b0;

    // Request dropped while waiting for the arbiter.
    @(negedge clk);
    b.reg_req = 1'b1; b.reg_rd_wr_L = 1'b1; b.reg_addr = 22'h9;
    repeat (2) @(negedge clk);
    chk("drop_rd_req_up", 72'(b.rd_req), 72'd1);
    b.reg_req = 1'b0;
    @(negedge clk);
    chk("drop_rd_req_down", 72'(b.rd_req), 72'd0);
    seen = 1'b0;
    repeat (4) begin @(negedge clk); seen |= b.reg_ack; end
    chk("drop_no_ack", 72'(seen), 72'd0);
    stall = 1'b0;

    for (int i = 0; i < 60; i++)
      xact(1'($urandom_range(0, 1)), 22'($urandom_range(0, 31)), $urandom);

    // Reset while a write-back is outstanding clears requests and the buffer.
    xact(1'b1, 22'h9, 32'h0);
    stall = 1'b1;
    @(negedge clk);
    b.reg_req = 1'b1; b.reg_rd_wr_L = 1'b0; b.reg_addr = 22'h9; b.reg_wr_data = 32'h5555AAAA;
    lat = 0;
    do begin @(negedge clk); lat++; end while (!(b.wr_req || b.rd_req) && lat < 20);
    chk("t6_wr_req", 72'(b.wr_req), CACHE ? 72'd1 : 72'd0);
    #2 reset_n = 1'b0;
    b.reg_req = 1'b0;
    #1;
    chk("t6_async_wr", 72'(b.wr_req), 72'd0);
    chk("t6_async_rd", 72'(b.rd_req), 72'd0);
    @(negedge clk);
    reset_n = 1'b1;
    stall = 1'b0;
    cvalid = 1'b0;
    xact(1'b1, 22'h9, 32'h0);

    for (int i = 0; i < 8; i++) chk($sformatf("mem%0d", i), sram[i], ref_mem[i]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
